// File: rtl/micro_pattern_gen_if.sv
// Tile pin bundle for the pattern generator: 8 dedicated inputs in, pattern out.
`timescale 1ns/1ps
interface micro_pattern_gen_if #(
    parameter int WIDTH = 8
);
    logic [7:0]       ui_in;
    logic [WIDTH-1:0] uo_out;

    modport master (output ui_in, input uo_out);
    modport slave  (input ui_in, output uo_out);
endinterface

// File: rtl/micro_pattern_gen.sv
// Pattern generator (counter / Galois LFSR / Johnson / walking one-hot) with prescaler,
// single-step input and a synchroniser on the tile inputs.
`timescale 1ns/1ps
module micro_pattern_gen #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8,
    parameter logic [WIDTH-1:0] SEED      = 8'h01,
    parameter int               SYNC      = 2
) (
    input  logic              clk,
    input  logic              rst,
    micro_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {
        M_CNT    = 2'd0,
        M_LFSR   = 2'd1,
        M_JOHN   = 2'd2,
        M_ONEHOT = 2'd3
    } mode_e;

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [7:0]       sync_q [SYNC];
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [3:0]       pre_q, pre_d;
    logic             stepp_q, stepp_d;

    logic [7:0] ui_s;
    mode_e      mode_s;
    logic       run_s, step_s, adv;
    logic [3:0] div_s;

    function automatic logic [WIDTH-1:0] seed_of(input mode_e m);
        case (m)
            M_LFSR:   return SEED_EFF;
            M_ONEHOT: return WIDTH'(1);
            default:  return '0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] next_pat(input mode_e m, input logic [WIDTH-1:0] s);
        case (m)
            M_CNT:   return s + WIDTH'(1);
            M_LFSR:  return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
            M_JOHN:  return {s[WIDTH-2:0], ~s[WIDTH-1]};
            default: return {s[WIDTH-2:0], s[WIDTH-1]};
        endcase
    endfunction

    assign ui_s   = sync_q[SYNC-1];
    assign mode_s = mode_e'(ui_s[1:0]);
    assign run_s  = ui_s[2];
    assign step_s = ui_s[3];
    assign div_s  = ui_s[7:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
            mode_q  <= M_CNT;
            pat_q   <= '0;
            pre_q   <= '0;
            stepp_q <= 1'b0;
        end else begin
            sync_q[0] <= bus.ui_in;
            for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            pre_q   <= pre_d;
            stepp_q <= stepp_d;
        end
    end

    always_comb begin
        mode_d  = mode_q;
        pat_d   = pat_q;
        pre_d   = pre_q;
        stepp_d = step_s;
        adv     = 1'b0;
        if (mode_s != mode_q) begin
            // Mode switch reloads the seed; any step edge seen this cycle is consumed.
            mode_d = mode_s;
            pat_d  = seed_of(mode_s);
            pre_d  = '0;
        end else begin
            if (run_s) begin
                if (pre_q >= div_s) begin
                    adv   = 1'b1;
                    pre_d = '0;
                end else begin
                    pre_d = pre_q + 4'd1;
                end
            end else begin
                pre_d = '0;
                adv   = step_s & ~stepp_q;
            end
            if (mode_q == M_LFSR && pat_q == '0) pat_d = SEED_EFF;
            else if (adv)                         pat_d = next_pat(mode_q, pat_q);
        end
    end

    assign bus.uo_out = pat_q;
endmodule

// File: tb/tb_micro_pattern_gen.sv
// Randomised and directed bench for micro_pattern_gen against an index-based reference model.
`timescale 1ns/1ps
module tb_micro_pattern_gen;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    micro_pattern_gen_if #(.WIDTH(8)) bus ();

    micro_pattern_gen #(.WIDTH(8), .LFSR_TAPS(8'hB8), .SEED(8'h01), .SYNC(SYNC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: counter/LFSR hold a value, Johnson/one-hot hold a position index.
    int m_sync [SYNC];
    int m_mode, m_pre, m_stepp, m_val, m_k;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h want %02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_out();
        case (m_mode)
            0, 1:    return 8'(m_val);
            2:       return (m_k <= 8) ? 8'((1 << m_k) - 1) : 8'((255 << (m_k - 8)) & 255);
            default: return 8'(1 << m_k);
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < SYNC; i++) m_sync[i] = 0;
        m_mode = 0; m_pre = 0; m_stepp = 0; m_val = 0; m_k = 0;
    endtask

    task automatic m_update(input logic [7:0] ui);
        int s, mode, run, stp, d, adv;
        s    = m_sync[SYNC-1];
        mode = s % 4;
        run  = (s / 4) % 2;
        stp  = (s / 8) % 2;
        d    = s / 16;
        if (mode != m_mode) begin
            m_mode = mode;
            m_pre  = 0;
            m_val  = (mode == 1) ? 1 : 0;
            m_k    = 0;
        end else begin
            adv = 0;
            if (run != 0) begin
                if (m_pre >= d) begin adv = 1; m_pre = 0; end
                else m_pre = m_pre + 1;
            end else begin
                m_pre = 0;
                adv = (stp == 1 && m_stepp == 0) ? 1 : 0;
            end
            if (adv != 0) begin
                case (m_mode)
                    0: m_val = (m_val + 1) % 256;
                    1: m_val = (m_val % 2 == 1) ? ((m_val / 2) ^ 'hB8) : (m_val / 2);
                    2: m_k = (m_k + 1) % 16;
                    default: m_k = (m_k + 1) % 8;
                endcase
            end
        end
        m_stepp = stp;
        for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = int'(ui);
    endtask

    task automatic step_clk();
        @(posedge clk);
        if (!rst) m_update(bus.ui_in);
        #1;
        check_val("model", bus.uo_out, m_out());
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step_clk();
    endtask

    task automatic mid_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        m_reset();
        check_val(tag, bus.uo_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] a, b;
        logic [7:0] lfsr_exp [5];
        logic [7:0] john_exp [3];
        bit found;
        lfsr_exp = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
        john_exp = '{8'h01, 8'h03, 8'h07};

        // reset and idle
        bus.ui_in = 8'h00;
        m_reset();
        repeat (3) @(posedge clk);
        #1 check_val("rst_state", bus.uo_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step_clk();
            check_val("idle", bus.uo_out, 8'h00);
        end

        // counter, D=0: first increment on the third edge, wrap FF->00
        bus.ui_in = 8'h04;
        step_clk(); check_val("cnt_lat1", bus.uo_out, 8'h00);
        step_clk(); check_val("cnt_lat2", bus.uo_out, 8'h00);
        step_clk(); check_val("cnt_first", bus.uo_out, 8'h01);
        step_clk(); check_val("cnt_2", bus.uo_out, 8'h02);
        step_clk(); check_val("cnt_3", bus.uo_out, 8'h03);
        steps(252);
        check_val("cnt_ff", bus.uo_out, 8'hFF);
        step_clk(); check_val("cnt_wrap", bus.uo_out, 8'h00);

        // counter, D=3 then D=0 mid-count
        bus.ui_in = 8'h34;
        steps(7);
        a = bus.uo_out;
        steps(8);
        b = bus.uo_out;
        check_val("d3_rate", b - a, 8'd2);
        steps(2);
        bus.ui_in = 8'h04;
        steps(6);
        a = bus.uo_out;
        steps(4);
        b = bus.uo_out;
        check_val("d0_rate", b - a, 8'd4);

        // LFSR
        bus.ui_in = 8'h05;
        steps(3);
        check_val("lfsr_seed", bus.uo_out, 8'h01);
        for (int i = 0; i < 5; i++) begin
            step_clk();
            check_val("lfsr_seq", bus.uo_out, lfsr_exp[i]);
        end
        steps(250);
        check_val("lfsr_period", bus.uo_out, 8'h01);

        // Johnson single-step
        bus.ui_in = 8'h02;
        steps(4);
        check_val("john_seed", bus.uo_out, 8'h00);
        for (int p = 0; p < 3; p++) begin
            bus.ui_in = 8'h0A; steps(4);
            bus.ui_in = 8'h02; steps(4);
            check_val("john_step", bus.uo_out, john_exp[p]);
        end
        bus.ui_in = 8'h0A;
        steps(4);
        a = bus.uo_out;
        steps(10);
        check_val("john_hold", bus.uo_out, a);

        // one-hot single-step
        bus.ui_in = 8'h03;
        steps(4);
        check_val("oh_seed", bus.uo_out, 8'h01);
        bus.ui_in = 8'h0B; steps(4);
        bus.ui_in = 8'h03; steps(4);
        check_val("oh_step1", bus.uo_out, 8'h02);
        bus.ui_in = 8'h0B; steps(4);
        bus.ui_in = 8'h03; steps(4);
        check_val("oh_step2", bus.uo_out, 8'h04);

        // async reset while counting
        bus.ui_in = 8'h04;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step_clk();
            if (bus.uo_out == 8'h5A) found = 1'b1;
        end
        check_val("reach_5a", {7'd0, found}, 8'd1);
        mid_reset("async_rst");
        step_clk(); check_val("rst_resume1", bus.uo_out, 8'h00);
        step_clk(); check_val("rst_resume2", bus.uo_out, 8'h00);
        step_clk(); check_val("rst_resume3", bus.uo_out, 8'h01);

        // randomised segments
        for (int seg = 0; seg < 300; seg++) begin
            logic [7:0] ui;
            ui = 8'($urandom);
            if ($urandom_range(0, 3) != 0) ui[7:4] = 4'($urandom_range(0, 3));
            bus.ui_in = ui;
            steps($urandom_range(1, 12));
            if ($urandom_range(0, 39) == 0) mid_reset("rand_rst");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
